ex_oitf: RTL and testbench
==========================

Name: ex_oitf

Overview:
Outstanding Instruction Track FIFO for long-pipe instructions such as LSU loads and stores. Dispatch allocates one entry per long-pipe instruction and hands back its itag, which travels with the instruction to the LSU. The long-pipe writeback arbiter downstream consumes the head entry through the ret_* outputs and frees it with ret_ena. The block also reports whether any in-flight destination register matches the dispatching instruction's sources or destination, so dispatch can stall on RAW/WAW hazards.

Parameters:
DEPTH, 2, number of entries; power of two, ≥2.
ITAG_WIDTH, 1, log2(DEPTH); width of entry index / itag.
RFIDX_WIDTH, 5, register index width.
PC_SIZE, 32, PC width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
dis_ready  out  1  an entry is free (FIFO not full).
dis_ena  in  1  allocate an entry this cycle; legal only when dis_ready=1.
disp_i_rs1en / disp_i_rs2en / disp_i_rs3en  in  1 each  source operand valid.
disp_i_rdwen  in  1  instruction writes rd.
disp_i_rs1fpu / disp_i_rs2fpu / disp_i_rs3fpu / disp_i_rdfpu  in  1 each  register-file select.
disp_i_rs1idx / disp_i_rs2idx / disp_i_rs3idx / disp_i_rdidx  in  RFIDX_WIDTH each  register indices.
disp_i_pc  in  PC_SIZE  PC of the dispatched instruction.
dis_ptr  out  ITAG_WIDTH  itag given to the allocating instruction (alloc pointer index).
ret_ena  in  1  retire the head entry this cycle; legal only when oitf_empty=0.
ret_ptr  out  ITAG_WIDTH  head entry index.
ret_rdidx  out  RFIDX_WIDTH  head rd index.
ret_rdwen  out  1  head writes rd.
ret_rdfpu  out  1  head rd is FPU.
ret_pc  out  PC_SIZE  head PC.
oitfrd_match_disprs1 / oitfrd_match_disprs2 / oitfrd_match_disprs3  out  1 each  RAW hazard on rs1 / rs2 / rs3.
oitfrd_match_disprd  out  1  WAW hazard on rd.
oitf_empty  out  1  no entries outstanding.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Pointers:
  - alc_ptr and ret_ptr are ITAG_WIDTH-bit indices, each paired with a wrap flag bit.
  - alc_ptr increments on dis_ena; ret_ptr increments on ret_ena.
  - On reaching DEPTH-1, a pointer wraps to 0 and toggles its flag.
- Full and empty:
  - empty = (alc_ptr==ret_ptr) & (alc_flg==ret_flg).
  - full = (alc_ptr==ret_ptr) & (alc_flg!=ret_flg).
  - dis_ready = ~full. oitf_empty = empty. dis_ptr = alc_ptr.
- Entry storage:
  - Each entry holds a valid bit plus rdwen, rdfpu, rdidx and pc.
  - On dis_ena: the entry at alc_ptr is written with disp_i_* and its valid bit is set.
  - On ret_ena: the entry at ret_ptr has its valid bit cleared.
  - Both events take effect at the rising edge. New state is visible the cycle after the edge.
- Simultaneous dis_ena and ret_ena: both pointers advance in the same cycle.
  - When not empty and not full, they address different entries and both updates apply.
  - When full, dis_ena is illegal. When empty, ret_ena is illegal.
- Retire outputs: ret_rdidx, ret_rdwen, ret_rdfpu and ret_pc are combinational reads of entry[ret_ptr], ANDed with ~oitf_empty. They are 0 when empty.
- Hazard matching (combinational, from registered state only; not bypassed from same-cycle dis_ena):
  - For each entry i: hit_rsK[i] = vld[i] & rdwen[i] & disp_i_rsKen & (rdfpu[i]==disp_i_rsKfpu) & (rdidx[i]==disp_i_rsKidx).
  - oitfrd_match_disprsK = OR over i of hit_rsK[i].
  - The rd match uses disp_i_rdwen, disp_i_rdfpu and disp_i_rdidx in the same form.
  - An index of 0 is not special-cased; the x0 hazard is filtered by dispatch.
- Reset values:
  - Pointers, flags and all valid bits are 0.
  - dis_ready=1, oitf_empty=1, dis_ptr=0, ret_ptr=0.
  - All ret_* outputs are 0 and all match outputs are 0.
  - Entry payload registers are not reset; they are masked by the valid bits and the empty gating.
  - Reset asserted mid-operation discards all outstanding entries immediately (asynchronous).
- Latency: allocation to head visibility is 1 cycle when the FIFO was empty. A freed entry is re-allocatable the cycle after ret_ena.
- Illegal events: dis_ena while full and ret_ena while empty are flagged by bench assertions. The RTL takes no corrective action.

Test Plan:
1. Reset -> oitf_empty=1, dis_ready=1, dis_ptr=0, ret_pc=0, all match outputs 0.
2. dis_ena with rdidx=5, rdwen=1, pc=0x80000010 -> next cycle: oitf_empty=0, ret_ptr=0, ret_rdidx=5, ret_pc=0x80000010, dis_ptr=1.
3. Second dis_ena (rdidx=7) with DEPTH=2 -> dis_ready=0. A third dis_ena attempt fires the assertion. ret_ena -> dis_ready=1, ret_ptr=1, ret_rdidx=7.
4. With entry rdidx=5 and rdfpu=0 outstanding: disp_i_rs2en=1, rs2idx=5 -> oitfrd_match_disprs2=1. The same with rs2fpu=1 -> 0. The same with rs2en=0 -> 0.
5. Simultaneous dis_ena and ret_ena with one entry held, repeated 10 cycles -> occupancy stays 1, flags toggle every DEPTH cycles, ret_pc tracks FIFO order.
6. Assert rst_n low mid-stream with 2 entries held -> oitf_empty=1 and match outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/ex_oitf.sv
`default_nettype none
// ============================================================================
//  Module   : ex_oitf
//  Brief    : Outstanding Instruction Track FIFO for long-pipe instructions.
//             Dispatch allocates an entry and receives its itag. The long-pipe
//             writeback side drains the head entry. Every valid entry's rd is
//             compared with the dispatching instruction's operands so that
//             dispatch can stall on RAW/WAW hazards.
//  Revision : 1.0  initial release
// ============================================================================
module ex_oitf #(
    parameter int DEPTH       = 2,
    parameter int ITAG_WIDTH  = 1,
    parameter int RFIDX_WIDTH = 5,
    parameter int PC_SIZE     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,

    output logic                   dis_ready,
    input  logic                   dis_ena,
    input  logic                   disp_i_rs1en,
    input  logic                   disp_i_rs2en,
    input  logic                   disp_i_rs3en,
    input  logic                   disp_i_rdwen,
    input  logic                   disp_i_rs1fpu,
    input  logic                   disp_i_rs2fpu,
    input  logic                   disp_i_rs3fpu,
    input  logic                   disp_i_rdfpu,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rs1idx,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rs2idx,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rs3idx,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rdidx,
    input  logic [PC_SIZE-1:0]     disp_i_pc,
    output logic [ITAG_WIDTH-1:0]  dis_ptr,

    input  logic                   ret_ena,
    output logic [ITAG_WIDTH-1:0]  ret_ptr,
    output logic [RFIDX_WIDTH-1:0] ret_rdidx,
    output logic                   ret_rdwen,
    output logic                   ret_rdfpu,
    output logic [PC_SIZE-1:0]     ret_pc,

    output logic                   oitfrd_match_disprs1,
    output logic                   oitfrd_match_disprs2,
    output logic                   oitfrd_match_disprs3,
    output logic                   oitfrd_match_disprd,
    output logic                   oitf_empty
);

    localparam logic [ITAG_WIDTH-1:0] c_last_idx = ITAG_WIDTH'(DEPTH - 1);

    // Pointers with wrap flags distinguish full from empty when indices meet.
    logic [ITAG_WIDTH-1:0]  r_alc_ptr;
    logic                   r_alc_flg;
    logic [ITAG_WIDTH-1:0]  r_ret_ptr;
    logic                   r_ret_flg;

    // Valid bits are reset; payload is masked by valid/empty and left unreset.
    logic [DEPTH-1:0]       r_vld;
    logic                   r_rdwen [DEPTH];
    logic                   r_rdfpu [DEPTH];
    logic [RFIDX_WIDTH-1:0] r_rdidx [DEPTH];
    logic [PC_SIZE-1:0]     r_pc    [DEPTH];

    logic                   w_ptr_eq;
    logic                   w_empty;
    logic                   w_full;

    logic [DEPTH-1:0]       w_hit_rs1;
    logic [DEPTH-1:0]       w_hit_rs2;
    logic [DEPTH-1:0]       w_hit_rs3;
    logic [DEPTH-1:0]       w_hit_rd;

    // Allocation pointer advances on each dispatch, toggling its flag on wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alc_ptr <= '0;
            r_alc_flg <= 1'b0;
        end else if (dis_ena) begin
            if (r_alc_ptr == c_last_idx) begin
                r_alc_ptr <= '0;
                r_alc_flg <= ~r_alc_flg;
            end else begin
                r_alc_ptr <= r_alc_ptr + 1'b1;
            end
        end
    end

    // Retire pointer advances on each retire, toggling its flag on wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ret_ptr <= '0;
            r_ret_flg <= 1'b0;
        end else if (ret_ena) begin
            if (r_ret_ptr == c_last_idx) begin
                r_ret_ptr <= '0;
                r_ret_flg <= ~r_ret_flg;
            end else begin
                r_ret_ptr <= r_ret_ptr + 1'b1;
            end
        end
    end

    // Valid bits: set on allocate, cleared on retire. Legal traffic never
    // targets the same entry with both in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            if (ret_ena) begin
                r_vld[r_ret_ptr] <= 1'b0;
            end
            if (dis_ena) begin
                r_vld[r_alc_ptr] <= 1'b1;
            end
        end
    end

    // Capture the dispatched instruction's rd info and PC into its entry.
    always_ff @(posedge clk) begin
        if (dis_ena) begin
            r_rdwen[r_alc_ptr] <= disp_i_rdwen;
            r_rdfpu[r_alc_ptr] <= disp_i_rdfpu;
            r_rdidx[r_alc_ptr] <= disp_i_rdidx;
            r_pc[r_alc_ptr]    <= disp_i_pc;
        end
    end

    assign w_ptr_eq   = (r_alc_ptr == r_ret_ptr);
    assign w_empty    = w_ptr_eq & (r_alc_flg == r_ret_flg);
    assign w_full     = w_ptr_eq & (r_alc_flg != r_ret_flg);

    assign dis_ready  = ~w_full;
    assign oitf_empty = w_empty;
    assign dis_ptr    = r_alc_ptr;
    assign ret_ptr    = r_ret_ptr;

    // Head entry read, forced to zero while nothing is outstanding.
    assign ret_rdidx  = r_rdidx[r_ret_ptr] & {RFIDX_WIDTH{~w_empty}};
    assign ret_rdwen  = r_rdwen[r_ret_ptr] & ~w_empty;
    assign ret_rdfpu  = r_rdfpu[r_ret_ptr] & ~w_empty;
    assign ret_pc     = r_pc[r_ret_ptr] & {PC_SIZE{~w_empty}};

    // Per-entry hazard comparison against registered state only; x0 is left
    // to dispatch to filter.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            logic w_live;
            assign w_live = r_vld[i] & r_rdwen[i];

            assign w_hit_rs1[i] = w_live & disp_i_rs1en
                                & (r_rdfpu[i] == disp_i_rs1fpu)
                                & (r_rdidx[i] == disp_i_rs1idx);
            assign w_hit_rs2[i] = w_live & disp_i_rs2en
                                & (r_rdfpu[i] == disp_i_rs2fpu)
                                & (r_rdidx[i] == disp_i_rs2idx);
            assign w_hit_rs3[i] = w_live & disp_i_rs3en
                                & (r_rdfpu[i] == disp_i_rs3fpu)
                                & (r_rdidx[i] == disp_i_rs3idx);
            assign w_hit_rd[i]  = w_live & disp_i_rdwen
                                & (r_rdfpu[i] == disp_i_rdfpu)
                                & (r_rdidx[i] == disp_i_rdidx);
        end
    endgenerate

    assign oitfrd_match_disprs1 = |w_hit_rs1;
    assign oitfrd_match_disprs2 = |w_hit_rs2;
    assign oitfrd_match_disprs3 = |w_hit_rs3;
    assign oitfrd_match_disprd  = |w_hit_rd;

endmodule
`default_nettype wire

// File: tb/tb_ex_oitf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_oitf
//  Brief    : Directed self-checking bench for ex_oitf (DEPTH=2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_oitf;

    localparam int DEPTH       = 2;
    localparam int ITAG_WIDTH  = 1;
    localparam int RFIDX_WIDTH = 5;
    localparam int PC_SIZE     = 32;

    logic                   clk;
    logic                   rst_n;
    logic                   dis_ready;
    logic                   dis_ena;
    logic                   disp_i_rs1en, disp_i_rs2en, disp_i_rs3en, disp_i_rdwen;
    logic                   disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu, disp_i_rdfpu;
    logic [RFIDX_WIDTH-1:0] disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx, disp_i_rdidx;
    logic [PC_SIZE-1:0]     disp_i_pc;
    logic [ITAG_WIDTH-1:0]  dis_ptr;
    logic                   ret_ena;
    logic [ITAG_WIDTH-1:0]  ret_ptr;
    logic [RFIDX_WIDTH-1:0] ret_rdidx;
    logic                   ret_rdwen;
    logic                   ret_rdfpu;
    logic [PC_SIZE-1:0]     ret_pc;
    logic                   oitfrd_match_disprs1, oitfrd_match_disprs2;
    logic                   oitfrd_match_disprs3, oitfrd_match_disprd;
    logic                   oitf_empty;

    int errors = 0;
    int checks = 0;

    ex_oitf #(
        .DEPTH      (DEPTH),
        .ITAG_WIDTH (ITAG_WIDTH),
        .RFIDX_WIDTH(RFIDX_WIDTH),
        .PC_SIZE    (PC_SIZE)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .dis_ready           (dis_ready),
        .dis_ena             (dis_ena),
        .disp_i_rs1en        (disp_i_rs1en),
        .disp_i_rs2en        (disp_i_rs2en),
        .disp_i_rs3en        (disp_i_rs3en),
        .disp_i_rdwen        (disp_i_rdwen),
        .disp_i_rs1fpu       (disp_i_rs1fpu),
        .disp_i_rs2fpu       (disp_i_rs2fpu),
        .disp_i_rs3fpu       (disp_i_rs3fpu),
        .disp_i_rdfpu        (disp_i_rdfpu),
        .disp_i_rs1idx       (disp_i_rs1idx),
        .disp_i_rs2idx       (disp_i_rs2idx),
        .disp_i_rs3idx       (disp_i_rs3idx),
        .disp_i_rdidx        (disp_i_rdidx),
        .disp_i_pc           (disp_i_pc),
        .dis_ptr             (dis_ptr),
        .ret_ena             (ret_ena),
        .ret_ptr             (ret_ptr),
        .ret_rdidx           (ret_rdidx),
        .ret_rdwen           (ret_rdwen),
        .ret_rdfpu           (ret_rdfpu),
        .ret_pc              (ret_pc),
        .oitfrd_match_disprs1(oitfrd_match_disprs1),
        .oitfrd_match_disprs2(oitfrd_match_disprs2),
        .oitfrd_match_disprs3(oitfrd_match_disprs3),
        .oitfrd_match_disprd (oitfrd_match_disprd),
        .oitf_empty          (oitf_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Illegal handshakes: dispatch while full, retire while empty.
    always @(posedge clk) begin
        if (rst_n && (dis_ena || ret_ena)) begin
            checks++;
            assert (!(dis_ena && !dis_ready) && !(ret_ena && oitf_empty)) else begin
                errors++;
                $error("FAIL illegal_handshake: dis_ena=%0b dis_ready=%0b ret_ena=%0b empty=%0b",
                       dis_ena, dis_ready, ret_ena, oitf_empty);
            end
        end
    end

    task automatic clear_srcs();
        disp_i_rs1en = 0; disp_i_rs2en = 0; disp_i_rs3en = 0; disp_i_rdwen = 0;
        disp_i_rs1fpu = 0; disp_i_rs2fpu = 0; disp_i_rs3fpu = 0; disp_i_rdfpu = 0;
        disp_i_rs1idx = '0; disp_i_rs2idx = '0; disp_i_rs3idx = '0; disp_i_rdidx = '0;
        disp_i_pc = '0;
    endtask

    // Drive one cycle of traffic, then return 1 time unit after the edge.
    task automatic cycle(input logic dis, input logic ret,
                         input logic [RFIDX_WIDTH-1:0] rd, input logic [PC_SIZE-1:0] pc);
        dis_ena      = dis;
        ret_ena      = ret;
        disp_i_rdwen = dis;
        disp_i_rdfpu = 1'b0;
        disp_i_rdidx = rd;
        disp_i_pc    = pc;
        @(posedge clk);
        #1;
        dis_ena = 1'b0;
        ret_ena = 1'b0;
        clear_srcs();
        #1;
    endtask

    initial begin
        logic [PC_SIZE-1:0] exp_pc;
        dis_ena = 0;
        ret_ena = 0;
        clear_srcs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Enables on with index 0: nothing valid, so no hit allowed.
        disp_i_rs1en = 1; disp_i_rdwen = 1;
        #1;

        // Reset state
        chk("rst_empty", oitf_empty, 1);
        chk("rst_ready", dis_ready, 1);
        chk("rst_dis_ptr", dis_ptr, 0);
        chk("rst_ret_ptr", ret_ptr, 0);
        chk("rst_ret_pc", ret_pc, 0);
        chk("rst_ret_rdidx", ret_rdidx, 0);
        chk("rst_match_rs1", oitfrd_match_disprs1, 0);
        chk("rst_match_rd", oitfrd_match_disprd, 0);
        clear_srcs();

        // First allocation becomes head next cycle
        cycle(1, 0, 5'd5, 32'h8000_0010);
        chk("a1_empty", oitf_empty, 0);
        chk("a1_ret_ptr", ret_ptr, 0);
        chk("a1_ret_rdidx", ret_rdidx, 5);
        chk("a1_ret_rdwen", ret_rdwen, 1);
        chk("a1_ret_pc", ret_pc, 32'h8000_0010);
        chk("a1_dis_ptr", dis_ptr, 1);
        chk("a1_ready", dis_ready, 1);

        // Hazard on rs2 against outstanding x5 (int)
        disp_i_rs2en = 1; disp_i_rs2idx = 5'd5; disp_i_rs2fpu = 0;
        #1;
        chk("hz_rs2_hit", oitfrd_match_disprs2, 1);
        chk("hz_rs1_idle", oitfrd_match_disprs1, 0);
        disp_i_rs2fpu = 1;
        #1;
        chk("hz_rs2_fpu", oitfrd_match_disprs2, 0);
        disp_i_rs2fpu = 0; disp_i_rs2en = 0;
        #1;
        chk("hz_rs2_dis", oitfrd_match_disprs2, 0);
        disp_i_rs3en = 1; disp_i_rs3idx = 5'd6;
        disp_i_rdwen = 1; disp_i_rdidx = 5'd5;
        #1;
        chk("hz_rs3_miss", oitfrd_match_disprs3, 0);
        chk("hz_rd_hit", oitfrd_match_disprd, 1);
        clear_srcs();

        // Second allocation fills DEPTH=2
        cycle(1, 0, 5'd7, 32'h8000_0020);
        chk("a2_ready", dis_ready, 0);
        chk("a2_dis_ptr", dis_ptr, 0);
        chk("a2_ret_rdidx", ret_rdidx, 5);
        disp_i_rs1en = 1; disp_i_rs1idx = 5'd7;
        #1;
        chk("a2_rs1_hit7", oitfrd_match_disprs1, 1);
        clear_srcs();
        // A third dispatch is withheld because dis_ready is low.
        if (dis_ready) cycle(1, 0, 5'd9, 32'h8000_0030);
        chk("a3_still_full", dis_ready, 0);

        // Retire head; x7 becomes head
        cycle(0, 1, '0, '0);
        chk("r1_ready", dis_ready, 1);
        chk("r1_ret_ptr", ret_ptr, 1);
        chk("r1_ret_rdidx", ret_rdidx, 7);
        chk("r1_ret_pc", ret_pc, 32'h8000_0020);
        disp_i_rs1en = 1; disp_i_rs1idx = 5'd5;
        #1;
        chk("r1_rs1_freed", oitfrd_match_disprs1, 0);
        clear_srcs();

        // Steady state: allocate and retire together, occupancy stays 1
        for (int k = 0; k < 10; k++) begin
            exp_pc = 32'h9000_0000 + 32'(k * 4);
            cycle(1, 1, 5'(k + 1), exp_pc);
            chk("ss_empty", oitf_empty, 0);
            chk("ss_ready", dis_ready, 1);
            chk("ss_ret_pc", ret_pc, exp_pc);
            chk("ss_ret_ptr", ret_ptr, 64'(k % 2));
            chk("ss_dis_ptr", dis_ptr, 64'((k + 1) % 2));
        end

        // Fill to two entries, then asynchronous reset between edges
        cycle(1, 0, 5'd20, 32'h9000_0100);
        chk("f_ready", dis_ready, 0);
        disp_i_rs1en = 1; disp_i_rs1idx = 5'd20;
        disp_i_rs2en = 1; disp_i_rs2idx = 5'd10;
        #1;
        chk("f_rs1_hit", oitfrd_match_disprs1, 1);
        chk("f_rs2_hit", oitfrd_match_disprs2, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_empty", oitf_empty, 1);
        chk("ar_ready", dis_ready, 1);
        chk("ar_ret_pc", ret_pc, 0);
        chk("ar_rs1", oitfrd_match_disprs1, 0);
        chk("ar_rs2", oitfrd_match_disprs2, 0);
        chk("ar_dis_ptr", dis_ptr, 0);
        clear_srcs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
